// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its RAM.
package dmem_pkg;

  localparam int WORD_BITS = 32;
  localparam int BYTE_BITS = 8;
  localparam int LANES     = WORD_BITS / BYTE_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  // A request is rejected when it is not word-aligned or falls past the last RAM word.
  // Comparing the word index instead of the byte address avoids overflow of 4*depthWords.
  function automatic logic addrError(input logic [WORD_BITS-1:0] addr,
                                     input int unsigned         depthWords);
    logic [WORD_BITS-1:0] wordIndex;
    wordIndex = {2'b00, addr[WORD_BITS-1:2]};
    return (addr[1:0] != 2'b00) || (wordIndex >= 32'(depthWords));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM with per-byte write enables and a combinational read port.
// Contents are deliberately left unreset so the array maps onto plain RAM.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_BITS   = 5
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we,
  input  logic [ADDR_BITS-1:0] wordAddr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

  // Update only the byte lanes whose enable is set; other lanes keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[wordAddr][i*BYTE_BITS +: BYTE_BITS] <= wdata[i*BYTE_BITS +: BYTE_BITS];
      end
    end
  end

  assign rdata = mem[wordAddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, a fixed number of wait
// states, then a single held response beat. The RAM access is committed on the same
// edge that raises rsp_valid, so a reset during the wait phase cleanly aborts a write.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [WORD_BITS-1:0] req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  input  logic [LANES-1:0]     req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_BITS-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int ADDR_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  stateT                state;
  logic [3:0]           waitCnt;
  logic                 wrReg;
  logic [WORD_BITS-1:0] addrReg;
  logic [WORD_BITS-1:0] wdataReg;
  logic [LANES-1:0]     beReg;

  logic                 selWr;
  logic [WORD_BITS-1:0] selAddr;
  logic [WORD_BITS-1:0] selWdata;
  logic [LANES-1:0]     selBe;
  logic                 cmdErr;
  logic                 commitNow;
  logic [LANES-1:0]     ramWe;
  logic [WORD_BITS-1:0] ramRdata;
  logic [WORD_BITS-1:0] commitRdata;

  // With zero wait states the commit happens on the accepting edge, so the live request
  // is used; otherwise the latched copy is used because the inputs may have moved on.
  always_comb begin
    selWr       = wrReg;
    selAddr     = addrReg;
    selWdata    = wdataReg;
    selBe       = beReg;
    if (state == IDLE) begin
      selWr    = req_wr;
      selAddr  = req_addr;
      selWdata = req_wdata;
      selBe    = req_be;
    end
    cmdErr      = addrError(selAddr, DEPTH_WORDS);
    commitNow   = !rst && (((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                           ((state == WAIT) && (waitCnt == 4'd0)));
    ramWe       = (commitNow && selWr && !cmdErr) ? selBe : '0;
    commitRdata = (cmdErr || selWr) ? '0 : ramRdata;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .we      (ramWe),
    .wordAddr(selAddr[ADDR_BITS+1:2]),
    .wdata   (selWdata),
    .rdata   (ramRdata)
  );

  // Request/response FSM with the wait counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      wrReg     <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
      beReg     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wrReg     <= req_wr;
            addrReg   <= req_addr;
            wdataReg  <= req_wdata;
            beReg     <= req_be;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= commitRdata;
              rsp_err   <= cmdErr;
            end else begin
              state   <= WAIT;
              waitCnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= commitRdata;
            rsp_err   <= cmdErr;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with 1, 0 and 15 wait states,
// checked against a word-array model of the RAM and the latency/error rules.
module tb_dmem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid [NDUT];
  logic        reqReady [NDUT];
  logic        rspValid [NDUT];
  logic        rspReady [NDUT];
  logic        rspErr   [NDUT];
  logic [31:0] rspRdata [NDUT];
  logic        reqWr;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqBe;

  int testCount = 0;
  int failCount = 0;
  logic [31:0] modelMem [NDUT][DEPTH];

  always #5 clk = ~clk;

  function automatic int wsOf(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(reqValid[g]),
      .req_ready(reqReady[g]),
      .req_wr   (reqWr),
      .req_addr (reqAddr),
      .req_wdata(reqWdata),
      .req_be   (reqBe),
      .rsp_valid(rspValid[g]),
      .rsp_ready(rspReady[g]),
      .rsp_rdata(rspRdata[g]),
      .rsp_err  (rspErr[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One full transaction on instance d. abortAt: 0 normal, 1 reset during WAIT, 2 reset during RESP.
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int hold, input int abortAt);
    int          lat;
    logic        expErr;
    logic [31:0] expData;
    expErr  = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    expData = (expErr || wr) ? 32'h0 : modelMem[d][addr[6:2]];
    checkOutput($sformatf("dut%0d_ready_idle", d), 32'(reqReady[d]), 32'h1);
    reqValid[d] = 1'b1;
    reqWr       = wr;
    reqAddr     = addr;
    reqWdata    = wdata;
    reqBe       = be;
    rspReady[d] = (hold == 0);
    @(posedge clk); #1;
    reqValid[d] = 1'b0;
    reqWr       = 1'($urandom);
    reqAddr     = $urandom;
    reqWdata    = $urandom;
    reqBe       = 4'($urandom);
    if (abortAt == 1) begin
      rst = 1'b1;
      #1;
      checkOutput("abort_wait_valid", 32'(rspValid[d]), 32'h0);
      checkOutput("abort_wait_ready", 32'(reqReady[d]), 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("after_abort_valid", 32'(rspValid[d]), 32'h0);
      return;
    end
    lat = 0;
    while (rspValid[d] !== 1'b1 && lat < 40) begin
      checkOutput($sformatf("dut%0d_ready_busy", d), 32'(reqReady[d]), 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("dut%0d_latency", d), 32'(lat), 32'(wsOf(d)));
    checkOutput($sformatf("dut%0d_err_a%08h", d, addr), 32'(rspErr[d]), 32'(expErr));
    checkOutput($sformatf("dut%0d_rdata_a%08h", d, addr), rspRdata[d], expData);
    checkOutput($sformatf("dut%0d_ready_resp", d), 32'(reqReady[d]), 32'h0);
    if (!expErr && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) modelMem[d][addr[6:2]][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    if (abortAt == 2) begin
      rst = 1'b1;
      #1;
      checkOutput("abort_resp_valid", 32'(rspValid[d]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(rspValid[d]), 32'h1);
      checkOutput("hold_rdata", rspRdata[d], expData);
      checkOutput("hold_err", 32'(rspErr[d]), 32'(expErr));
      checkOutput("hold_ready", 32'(reqReady[d]), 32'h0);
    end
    rspReady[d] = 1'b1;
    @(posedge clk); #1;
    checkOutput($sformatf("dut%0d_done_valid", d), 32'(rspValid[d]), 32'h0);
    checkOutput($sformatf("dut%0d_done_ready", d), 32'(reqReady[d]), 32'h1);
    rspReady[d] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          d;
    int          word;
    int          hold;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    rst      = 1'b1;
    reqWr    = 1'b0;
    reqAddr  = 32'h0;
    reqWdata = 32'h0;
    reqBe    = 4'h0;
    for (int i = 0; i < NDUT; i++) begin
      reqValid[i] = 1'b0;
      rspReady[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("reset_ready%0d", i), 32'(reqReady[i]), 32'h1);
      checkOutput($sformatf("reset_valid%0d", i), 32'(rspValid[i]), 32'h0);
      checkOutput($sformatf("reset_rdata%0d", i), rspRdata[i], 32'h0);
      checkOutput($sformatf("reset_err%0d", i), 32'(rspErr[i]), 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
    applyStimulus(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
    applyStimulus(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 0, 0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
    applyStimulus(0, 1'b0, 32'h80, 32'h0, 4'h0, 0, 0);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, 0);
    applyStimulus(0, 1'b1, 32'h90, 32'hFFFFFFFF, 4'hF, 0, 0);
    applyStimulus(0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 0, 0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 0);

    applyStimulus(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 0, 0);
    applyStimulus(0, 1'b1, 32'h20, 32'h22222222, 4'hF, 0, 1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0);
    applyStimulus(0, 1'b1, 32'h24, 32'h33333333, 4'hF, 2, 2);
    applyStimulus(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, 0);

    for (int i = 0; i < NDUT; i++) begin
      for (int w = 0; w < 8; w++) begin
        applyStimulus(i, 1'b1, 32'(4 * w), $urandom, 4'hF, 0, 0);
      end
    end

    for (int i = 1; i < NDUT; i++) begin
      applyStimulus(i, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0);
      applyStimulus(i, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 0, 0);
      applyStimulus(i, 1'b0, 32'h8, 32'h0, 4'h0, 0, 0);
      applyStimulus(i, 1'b0, 32'h7D, 32'h0, 4'h0, 0, 0);
    end

    for (int n = 0; n < 60; n++) begin
      d    = int'($urandom_range(0, NDUT - 1));
      word = int'($urandom_range(0, 7));
      wr   = 1'($urandom);
      be   = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) addr = 32'h80 + 32'(4 * $urandom_range(0, 63));
        else                           addr = 32'(4 * word) + 32'($urandom_range(1, 3));
      end else begin
        addr = 32'(4 * word);
      end
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(d, wr, addr, $urandom, be, hold, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
